fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives imem requests and feeds an IF/ID register to decode.
// Latency: request accepted in cycle N, response in N+1, if_valid in N+2.
// Backpressure: id_ready=0 holds IF/ID; a blocked response is replayed (or parked in skid when FETCH_SKID_EN).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  logic [31:0] r_pc;
  logic        r_pend;
  logic        r_kill;
  logic [31:0] r_pend_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;

  logic        w_req_fire;
  logic        w_out_fire;
  logic        w_land;
  logic        w_if_free;
  logic        w_rsp_ok;
  logic        w_space;
  logic        w_drop;
  logic [31:0] w_tgt;

  // Redirect target forced to word alignment.
  assign w_tgt      = br_target & ~32'h0000_0003;
  assign w_out_fire = r_if_valid & id_ready;
  assign w_if_free  = ~r_if_valid | w_out_fire;
  // A response is live only if it answers our outstanding, unkilled request and
  // no redirect or reset is discarding it this cycle.
  assign w_land     = imem_rvalid & r_pend & ~r_kill & ~br_taken & ~rst;
  // Single outstanding request: a new one may go out once the previous returns.
  assign w_rsp_ok   = ~r_pend | imem_rvalid;

`ifdef FETCH_SKID_EN
  logic        r_sk_vld;
  logic [31:0] r_sk_pc;
  logic [31:0] r_sk_inst;
  logic [1:0]  w_occ_next;

  // Occupancy of IF/ID plus skid after this edge; a new request needs a free slot
  // for its response next cycle even if decode stays stalled.
  assign w_occ_next = {1'b0, r_if_valid} + {1'b0, r_sk_vld} + {1'b0, w_land} - {1'b0, w_out_fire};
  assign w_space    = (w_occ_next <= 2'd1);
  assign w_drop     = 1'b0;
`else
  // Only request when the IF/ID slot is free this cycle; a response that later
  // finds it blocked is dropped and its address refetched.
  assign w_space    = w_if_free;
  assign w_drop     = w_land & ~w_if_free;
`endif

  assign imem_req   = ~rst & ~br_taken & w_rsp_ok & w_space;
  assign imem_addr  = r_pc;
  assign w_req_fire = imem_req & imem_gnt;

  assign if_valid   = r_if_valid;
  assign if_pc      = r_if_pc;
  assign if_inst    = r_if_valid ? r_if_inst : NOP_INST;

  // Fetch PC: reset, redirect, replay of a dropped response, or advance on accept.
  always_ff @(posedge clk) begin
    if (rst)             r_pc <= RESET_PC;
    else if (br_taken)   r_pc <= w_tgt;
    else if (w_drop)     r_pc <= r_pend_pc;
    else if (w_req_fire) r_pc <= r_pc + 32'd4;
  end

  // Outstanding-request tracking: pending flag, its PC, and whether it was killed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= 1'b0;
      r_kill    <= 1'b0;
      r_pend_pc <= RESET_PC;
    end else begin
      if (w_req_fire) begin
        r_pend    <= 1'b1;
        r_pend_pc <= r_pc;
      end else if (imem_rvalid) begin
        r_pend    <= 1'b0;
      end
      if (br_taken)         r_kill <= r_pend & ~imem_rvalid;
      else if (imem_rvalid) r_kill <= 1'b0;
    end
  end

`ifdef FETCH_SKID_EN
  // IF/ID and skid: skid drains first, a response lands wherever the free slot is.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= RESET_PC;
      r_if_inst  <= NOP_INST;
      r_sk_vld   <= 1'b0;
      r_sk_pc    <= RESET_PC;
      r_sk_inst  <= NOP_INST;
    end else if (br_taken) begin
      r_if_valid <= 1'b0;
      r_sk_vld   <= 1'b0;
    end else if (w_if_free) begin
      if (r_sk_vld) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_sk_pc;
        r_if_inst  <= r_sk_inst;
        r_sk_vld   <= w_land;
        if (w_land) begin
          r_sk_pc   <= r_pend_pc;
          r_sk_inst <= imem_rdata;
        end
      end else begin
        r_if_valid <= w_land;
        if (w_land) begin
          r_if_pc   <= r_pend_pc;
          r_if_inst <= imem_rdata;
        end
      end
    end else if (w_land) begin
      r_sk_vld  <= 1'b1;
      r_sk_pc   <= r_pend_pc;
      r_sk_inst <= imem_rdata;
    end
  end
`else
  // IF/ID register: loads a live response when free, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= RESET_PC;
      r_if_inst  <= NOP_INST;
    end else if (br_taken) begin
      r_if_valid <= 1'b0;
    end else if (w_if_free) begin
      r_if_valid <= w_land;
      if (w_land) begin
        r_if_pc   <= r_pend_pc;
        r_if_inst <= imem_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized run.
// Reference is a program-order stream model: each consumed word must be the next
// sequential PC since the last reset/redirect, carrying the memory word at that PC.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, br_taken, if_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, br_target, if_pc, if_inst;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = RST_PC;
  int          consumed = 0;
  int          idle = 0;
  int          max_idle = 0;
  logic        prev_redirect = 1'b0;
  logic [31:0] prev_tgt = 32'h0;
  logic [31:0] held_addr;
  int          cons_start;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
  );

  // Memory contents: distinct per address; word 0 is addi x1,x0,5.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample settled values before the edge, update the stream model,
  // then answer an accepted request exactly one cycle later.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    @(negedge clk);
    fire = imem_req & imem_gnt;
    a    = imem_addr;
    if (!if_valid) chk("nop_when_empty", if_inst, NOP);
    if (imem_req) chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
    if (rst || br_taken) chk("no_req_in_rst_or_br", {31'd0, imem_req}, 32'd0);
    if (prev_redirect && !rst && !br_taken) begin
      chk("req_after_redirect", {31'd0, imem_req}, 32'd1);
      chk("addr_after_redirect", imem_addr, prev_tgt);
    end
    if (rst) begin
      exp_pc = RST_PC;
      idle = 0;
    end else begin
      if (if_valid && id_ready) begin
        chk("stream_pc", if_pc, exp_pc);
        chk("stream_inst", if_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
        idle = 0;
      end else begin
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
      if (br_taken) exp_pc = {br_target[31:2], 2'b00};
    end
    prev_redirect = br_taken & ~rst;
    prev_tgt      = {br_target[31:2], 2'b00};
    @(posedge clk);
    #1;
    imem_rvalid = fire;
    imem_rdata  = fire ? mem_word(a) : $urandom;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; br_taken = 1'b0;
    br_target = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    #1;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_if_pc", if_pc, RST_PC);

    // First fetch after reset and its two-cycle latency.
    rst = 1'b0; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    tick(); #1;
    chk("first_lat_c1_empty", {31'd0, if_valid}, 32'd0);
    tick(); #1;
    chk("first_lat_c2_valid", {31'd0, if_valid}, 32'd1);
    chk("first_if_pc", if_pc, 32'h0);
    chk("first_if_inst", if_inst, 32'h0050_0093);

    // Decode stall of three cycles while 0x10 sits in IF/ID.
    for (int i = 0; i < 20 && !(if_valid && if_pc == 32'h10); i++) begin
      tick(); #1;
    end
    chk("stall_reach_0x10", if_pc, 32'h10);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'h10);
      chk("stall_inst", if_inst, mem_word(32'h10));
      tick();
    end
    id_ready = 1'b1; #1;
    chk("stall_release_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_SKID_EN
    chk("stall_release_addr", imem_addr, 32'h18);
`else
    chk("stall_release_addr", imem_addr, 32'h14);
`endif
    for (int k = 0; k < 5; k++) tick();

    // Grant withheld for four cycles.
    #1; held_addr = imem_addr;
    imem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("nogrant_req", {31'd0, imem_req}, 32'd1);
      chk("nogrant_addr", imem_addr, held_addr);
      tick();
    end
    #1;
    chk("nogrant_drained", {31'd0, if_valid}, 32'd0);
    imem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Redirect coincident with a response.
    #1;
    chk("redir_rvalid_present", {31'd0, imem_rvalid}, 32'd1);
    br_taken = 1'b1; br_target = 32'h203; #1;
    chk("redir_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    br_taken = 1'b0; #1;
    chk("redir_if_cleared", {31'd0, if_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h200);
    tick(); #1;
    chk("redir_killed_not_loaded", {31'd0, if_valid}, 32'd0);
    tick(); #1;
    chk("redir_target_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_target_pc", if_pc, 32'h200);

    // PC wrap at the top of the address space.
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0; #1;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("wrap_addr_zero", imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) tick();

    // Redirect held two cycles: last target wins.
    br_taken = 1'b1; br_target = 32'h400; tick();
    br_target = 32'h801; tick();
    br_taken = 1'b0; #1;
    chk("multi_redir_addr", imem_addr, 32'h800);
    for (int k = 0; k < 4; k++) tick();

    // Reset the cycle after a grant; a stray response after reset is ignored.
    #1;
    chk("rstmid_grant", {31'd0, imem_req & imem_gnt}, 32'd1);
    tick();
    rst = 1'b1; #1;
    chk("rstmid_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("rstmid_addr", imem_addr, RST_PC);
    chk("rstmid_empty", {31'd0, if_valid}, 32'd0);
    tick(); #1;
    chk("rstmid_stray_ignored", {31'd0, if_valid}, 32'd0);
    tick(); #1;
    chk("rstmid_valid", {31'd0, if_valid}, 32'd1);
    chk("rstmid_pc", if_pc, RST_PC);
    chk("rstmid_inst", if_inst, mem_word(RST_PC));

    // Randomized traffic checked by the stream model.
    cons_start = consumed;
    max_idle = 0;
    for (int n = 0; n < 3000; n++) begin
      imem_gnt  = ($urandom_range(0, 9) < 7);
      id_ready  = ($urandom_range(0, 9) < 7);
      br_taken  = ($urandom_range(0, 99) < 3);
      br_target = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    chk("rand_progress", {31'd0, (consumed - cons_start) > 300}, 32'd1);
    chk("rand_no_starvation", {31'd0, max_idle < 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
